// File: rtl/periph_bus_hub.sv
// Memory-mapped hub from the core data port to N_SLOTS peripheral slots, with bus timeout and error response.
// Define PBH_IRQ_EN to build the hub-local PEND/MASK interrupt aggregator; without it irq is tied low.
module periph_bus_hub #(
    parameter int N_SLOTS = 6,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        ready,
    output logic                        err,
    output logic [N_SLOTS-1:0]          slot_sel,
    output logic                        slot_we,
    output logic [DATA_W-1:0]           slot_wdata,
    input  logic [N_SLOTS*DATA_W-1:0]   slot_rdata,
    input  logic [N_SLOTS-1:0]          slot_ready,
    input  logic [N_SLOTS-1:0]          irq_in,
    output logic                        irq
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int TCNT_W = 8;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [N_SLOTS-1:0]  sel_q, sel_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [IDX_W-1:0]    idx;
    logic                is_slot;
    logic                slot_done;
    logic [DATA_W-1:0]   slot_mux;

`ifdef PBH_IRQ_EN
    localparam logic [IDX_W-1:0] PEND_IDX = IDX_W'(N_SLOTS);
    localparam logic [IDX_W-1:0] MASK_IDX = IDX_W'(N_SLOTS + 1);

    logic [N_SLOTS-1:0]  pend_q, pend_d;
    logic [N_SLOTS-1:0]  mask_q, mask_d;
    logic [N_SLOTS-1:0]  w1c;
    logic                irq_q, irq_d;
`endif

    assign idx     = addr[ADDR_W-1:2];
    assign is_slot = (idx < IDX_W'(N_SLOTS));

    // sel_q is one-hot while waiting, so masking replaces indexing by the captured slot number.
    assign slot_done = |(sel_q & slot_ready);

    always_comb begin
        slot_mux = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (sel_q[k]) slot_mux = slot_mux | slot_rdata[k*DATA_W +: DATA_W];
        end
    end

    // NOTE: every variable written in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = err_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        tcnt_d  = tcnt_q;
`ifdef PBH_IRQ_EN
        mask_d  = mask_q;
        w1c     = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (is_slot) begin
                        for (int k = 0; k < N_SLOTS; k++) begin
                            sel_d[k] = (idx == IDX_W'(k));
                        end
                        we_d    = we;
                        wdata_d = wdata;
                        tcnt_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
`ifdef PBH_IRQ_EN
                        if (idx == PEND_IDX) begin
                            err_d = 1'b0;
                            if (we) w1c = wdata[N_SLOTS-1:0];
                            else    rdata_d = DATA_W'(pend_q);
                        end else if (idx == MASK_IDX) begin
                            err_d = 1'b0;
                            if (we) mask_d = wdata[N_SLOTS-1:0];
                            else    rdata_d = DATA_W'(mask_q);
                        end
`endif
                    end
                end
            end
            S_WAIT: begin
                if (slot_done) begin
                    rdata_d = we_q ? '0 : slot_mux;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PBH_IRQ_EN
        // A request arriving in the same cycle as its clear survives.
        pend_d = (pend_q & ~w1c) | irq_in;
        irq_d  = |(pend_q & mask_q);
`endif
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef PBH_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];
`else
    assign irq = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{addr[1:0], irq_in};
`endif

    assign rdata      = rdata_q;
    assign ready      = ready_q;
    assign err        = err_q;
    assign slot_sel   = sel_q;
    assign slot_we    = we_q;
    assign slot_wdata = wdata_q;

endmodule

// File: tb/tb_periph_bus_hub.sv
// Self-checking bench for periph_bus_hub: directed steps plus randomized accesses against a latency/response model.
module tb_periph_bus_hub;
    localparam int N  = 6;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 15;

    logic            clk;
    logic            rst;
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            ready;
    logic            err;
    logic [N-1:0]    slot_sel;
    logic            slot_we;
    logic [DW-1:0]   slot_wdata;
    logic [N*DW-1:0] slot_rdata;
    logic [N-1:0]    slot_ready;
    logic [N-1:0]    irq_in;
    logic            irq;

    logic [DW-1:0]   slot_val [N];

    int n_checks = 0;
    int n_errors = 0;

    periph_bus_hub #(.N_SLOTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .slot_sel(slot_sel), .slot_we(slot_we),
        .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_ready(slot_ready),
        .irq_in(irq_in), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) slot_rdata[k*DW +: DW] = slot_val[k];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 2ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response predicted from the access rules: latency in cycles from the accept edge, err, rdata.
    function automatic void predict(input logic w, input int idx, input int delay,
                                    output int lat, output logic e, output logic [DW-1:0] rd);
        if (idx < N) begin
            if (delay < TO) begin
                lat = delay + 2;
                e   = 1'b0;
                rd  = w ? '0 : slot_val[idx];
            end else begin
                lat = TO + 1;
                e   = 1'b1;
                rd  = '0;
            end
        end else begin
            lat = 1;
            e   = 1'b1;
            rd  = '0;
        end
    endfunction

    // Issues one access; the addressed slot's ready rises once 'delay' waiting cycles have passed,
    // other slots' ready lines carry random noise.
    task automatic run_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int delay, output int lat, output logic [DW-1:0] rd,
                              output logic e, output logic side_ok);
        int idx;
        logic [N-1:0] exp_sel;
        idx     = int'(a >> 2);
        exp_sel = '0;
        if (idx < N) exp_sel[idx] = 1'b1;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = wd;
        tick();
        req     = 1'b0;
        lat     = -1;
        rd      = '0;
        e       = 1'b0;
        side_ok = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            if (ready) begin
                lat = c;
                rd  = rdata;
                e   = err;
                if (slot_sel !== '0 || slot_we !== 1'b0) side_ok = 1'b0;
                break;
            end
            if (slot_sel !== exp_sel || slot_we !== w || slot_wdata !== wd) side_ok = 1'b0;
            if (idx < N) begin
                slot_ready      = N'($urandom);
                slot_ready[idx] = (c > delay);
            end
            tick();
        end
        slot_ready = '0;
    endtask

    // Full access plus checks of latency, err, rdata, side signals and the single ready pulse.
    task automatic slot_txn(input string tag, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int delay);
        int lat, exp_lat;
        logic e, exp_e, side_ok;
        logic [DW-1:0] rd, exp_rd;
        predict(w, int'(a >> 2), delay, exp_lat, exp_e, exp_rd);
        run_access(w, a, wd, delay, lat, rd, e, side_ok);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(e), 64'(exp_e));
        check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
        check({tag, "_side"}, 64'(side_ok), 64'(1'b1));
        tick();
        check({tag, "_pulse"}, 64'(ready), 64'(1'b0));
    endtask

    initial begin
        int lat, pulses;
        logic e, side_ok;
        logic [DW-1:0] rd;
        logic [3:0] pattern;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        slot_ready = '0; irq_in = '0;
        for (int k = 0; k < N; k++) slot_val[k] = $urandom;
        tick(); tick();
        rst = 1'b0;
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_sel", 64'(slot_sel), 64'(0));
        check("rst_we", 64'(slot_we), 64'(0));
        check("rst_wdata", 64'(slot_wdata), 64'(0));
        check("rst_irq", 64'(irq), 64'(0));

        slot_val[2] = 32'hCAFE0002;
        slot_txn("rd_slot2", 1'b0, 5'd8, '0, 0);
        slot_txn("wr_slot1", 1'b1, 5'd4, 32'h5A, 3);
        slot_txn("timeout_slot3", 1'b0, 5'd12, 32'h0, 1000);
        slot_txn("edge_last_wait", 1'b0, 5'd20, 32'h0, TO - 1);
        slot_txn("edge_first_timeout", 1'b1, 5'd0, 32'h1234, TO);
        slot_txn("addr_lsb_ignored", 1'b0, 5'd11, 32'h0, 1);

`ifdef PBH_IRQ_EN
        irq_in = 6'h10;
        tick();
        irq_in = '0;
        run_access(1'b1, 5'd28, 32'h10, 0, lat, rd, e, side_ok);
        check("mask_wr_lat", 64'(lat), 64'(1));
        check("mask_wr_err", 64'(e), 64'(0));
        tick();
        check("irq_set", 64'(irq), 64'(1));
        run_access(1'b0, 5'd24, '0, 0, lat, rd, e, side_ok);
        check("pend_rd", 64'(rd), 64'(32'h10));
        check("pend_rd_err", 64'(e), 64'(0));
        run_access(1'b0, 5'd28, '0, 0, lat, rd, e, side_ok);
        check("mask_rd", 64'(rd), 64'(32'h10));
        run_access(1'b1, 5'd24, 32'h10, 0, lat, rd, e, side_ok);
        tick();
        check("irq_clear", 64'(irq), 64'(0));
        irq_in = 6'h10;
        run_access(1'b1, 5'd24, 32'h10, 0, lat, rd, e, side_ok);
        run_access(1'b0, 5'd24, '0, 0, lat, rd, e, side_ok);
        check("pend_set_wins", 64'(rd), 64'(32'h10));
        irq_in = '0;
        run_access(1'b1, 5'd24, 32'h10, 0, lat, rd, e, side_ok);
        run_access(1'b0, 5'd24, '0, 0, lat, rd, e, side_ok);
        check("pend_cleared", 64'(rd), 64'(0));
        addr = 5'd28;
`else
        slot_txn("unmapped_idx7", 1'b0, 5'd28, 32'h0, 0);
        slot_txn("unmapped_pend_slot", 1'b1, 5'd24, 32'hFFFF_FFFF, 0);
        irq_in = '1;
        tick(); tick(); tick();
        check("irq_tied_low", 64'(irq), 64'(0));
        irq_in = '0;
        addr = 5'd24;
`endif

        // Held request: accepted, ignored during the response, re-accepted once back in idle.
        we = 1'b0;
        req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            pattern[3-c] = ready;
        end
        req = 1'b0;
        tick();
        check("held_req_pattern", 64'(pattern), 64'(4'b1010));

        // Reset during a slot wait aborts without a response.
        req = 1'b1; we = 1'b0; addr = 5'd12;
        tick();
        req = 1'b0;
        tick(); tick();
        check("pre_rst_sel", 64'(slot_sel), 64'(6'b001000));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_sel", 64'(slot_sel), 64'(0));
        check("mid_rst_ready", 64'(ready), 64'(0));
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (ready) pulses++;
            tick();
        end
        check("mid_rst_no_pulse", 64'(pulses), 64'(0));
        slot_txn("post_rst_rd", 1'b0, 5'd0, 32'h0, 0);

        for (int i = 0; i < 24; i++) begin
            int idx, delay;
            logic w;
            logic [DW-1:0] wd;
            idx = $urandom_range(0, N + 1);
`ifdef PBH_IRQ_EN
            if (idx >= N) idx = $urandom_range(0, N - 1);
`endif
            w     = 1'($urandom_range(0, 1));
            wd    = $urandom;
            delay = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 5) : $urandom_range(0, 4);
            if (idx < N) slot_val[idx] = $urandom;
            slot_txn($sformatf("rnd%0d", i), w, AW'(idx * 4 + $urandom_range(0, 3)), wd, delay);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
